// File: rtl/ymc_ctrl.sv
// ymc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer that owns pc, IR and datapath controls.
// Build macro JAL_EN adds the jal instruction (opcode 0x03) and the Link output.
module ymc_ctrl #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(128),
  parameter int            ICNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       ins,
  input  logic              zero,
  input  logic [31:0]       imm,
  output logic [AW-1:0]     pc,
  output logic              RegDst,
  output logic              RegWrite,
  output logic              ALUSrc,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Mem2Reg,
  output logic [2:0]        op,
  output logic              halted,
  output logic              illegal,
  output logic [ICNT_W-1:0] icount
`ifdef JAL_EN
  ,
  output logic              Link
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_ILL, K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_J, K_JAL
  } kind_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     pc_reg, pc_next;
  logic [31:0]       ir_reg, ir_next;
  logic [ICNT_W-1:0] icount_reg;
  logic              illegal_reg, illegal_next;
  logic              retire;

  kind_t             kind;
  logic [2:0]        alu_op;

  // Jump/branch targets are built in a wide space so any AW >= 28 works without slicing past pc.
  logic [AW+31:0]    pc_x, tgt_x, imm_x;
  logic [31:0]       target32;
  logic [AW-1:0]     jump_pc, br_pc;
  logic              unused_bits;

  assign pc_x        = {32'b0, pc_reg};
  assign target32    = {pc_x[31:28], ir_reg[25:0], 2'b00};
  assign tgt_x       = {{AW{1'b0}}, target32};
  assign jump_pc     = tgt_x[AW-1:0];
  assign imm_x       = {{AW{imm[31]}}, imm};
  assign br_pc       = pc_reg + {imm_x[AW-3:0], 2'b00};
  assign unused_bits = ^{pc_x[AW+31:32], pc_x[27:0], tgt_x[AW+31:AW], imm_x[AW+31:AW-2]};

  always_comb begin
    kind   = K_ILL;
    alu_op = 3'b010;
    case (ir_reg[31:26])
      6'h00: begin
        kind = K_R;
        case (ir_reg[5:0])
          6'h20:   alu_op = 3'b010;
          6'h22:   alu_op = 3'b110;
          6'h24:   alu_op = 3'b000;
          6'h25:   alu_op = 3'b001;
          6'h2A:   alu_op = 3'b111;
          default: kind   = K_ILL;
        endcase
      end
      6'h23: kind = K_LW;
      6'h2B: kind = K_SW;
      6'h04: begin
        kind   = K_BEQ;
        alu_op = 3'b110;
      end
      6'h08: kind = K_ADDI;
      6'h02: kind = K_J;
`ifdef JAL_EN
      6'h03: kind = K_JAL;
`endif
      default: kind = K_ILL;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    illegal_next = illegal_reg;
    retire       = 1'b0;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    ALUSrc       = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    Mem2Reg      = 1'b0;
    op           = 3'b000;
`ifdef JAL_EN
    Link         = 1'b0;
`endif
    case (state_reg)
      S_IDLE: if (start) state_next = S_FETCH;
      S_FETCH: begin
        ir_next    = ins;
        pc_next    = pc_reg + AW'(4);
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (kind)
          K_ILL: begin
            state_next   = S_HALT;
            illegal_next = 1'b1;
          end
          K_J: begin
            pc_next    = jump_pc;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          K_JAL: begin
            pc_next    = jump_pc;
            state_next = S_WB;
          end
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        op     = alu_op;
        ALUSrc = (kind == K_LW) || (kind == K_SW) || (kind == K_ADDI);
        RegDst = (kind == K_R);
        if (kind == K_BEQ) begin
          retire     = 1'b1;
          state_next = S_FETCH;
          if (zero) pc_next = br_pc;
        end else if ((kind == K_LW) || (kind == K_SW)) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        op       = alu_op;
        ALUSrc   = 1'b1;
        MemRead  = (kind == K_LW);
        MemWrite = (kind == K_SW);
        if (kind == K_SW) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
        // jal writes the link value only; no ALU result is involved.
        if (kind != K_JAL) begin
          op      = alu_op;
          ALUSrc  = (kind == K_LW) || (kind == K_ADDI);
          RegDst  = (kind == K_R);
          MemRead = (kind == K_LW);
          Mem2Reg = (kind == K_LW);
        end
`ifdef JAL_EN
        else begin
          Link = 1'b1;
        end
`endif
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= RESET_PC;
      ir_reg      <= 32'b0;
      icount_reg  <= '0;
      illegal_reg <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      illegal_reg <= illegal_next;
      if (retire && (icount_reg != '1)) icount_reg <= icount_reg + 1'b1;
    end
  end

  assign pc      = pc_reg;
  assign icount  = icount_reg;
  assign halted  = (state_reg == S_HALT);
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_ymc_ctrl.sv
// tb_ymc_ctrl: random instruction stream against a per-instruction reference model, scoreboard-checked each cycle.
module tb_ymc_ctrl;
  localparam int AW     = 32;
  localparam int ICNT_W = 16;
  localparam int HALT_CYCLES = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic zero = 1'b0;
  logic [31:0] ins = 32'b0;
  logic [31:0] imm = 32'b0;
  logic [AW-1:0] pc;
  logic regdst, regwrite, alusrc, memread, memwrite, mem2reg;
  logic [2:0] op;
  logic halted, illegal, link;
  logic [ICNT_W-1:0] icount;

  ymc_ctrl #(.AW(AW), .RESET_PC(32'd128), .ICNT_W(ICNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .zero(zero), .imm(imm),
    .pc(pc), .RegDst(regdst), .RegWrite(regwrite), .ALUSrc(alusrc),
    .MemRead(memread), .MemWrite(memwrite), .Mem2Reg(mem2reg), .op(op),
    .halted(halted), .illegal(illegal), .icount(icount)
`ifdef JAL_EN
    , .Link(link)
`endif
  );
`ifndef JAL_EN
  assign link = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic        regdst, regwrite, alusrc, memread, memwrite, mem2reg;
    logic [2:0]  op;
    logic        link, halted, illegal;
    logic [31:0] pc;
    logic [15:0] icount;
  } obs_t;

  typedef enum {C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_LW, C_SW, C_BEQ, C_ADDI, C_J, C_JAL, C_BAD} cls_t;

  obs_t        expq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mpc;
  logic [15:0] mcnt;

  function automatic obs_t sample();
    obs_t a;
    a = '{regdst, regwrite, alusrc, memread, memwrite, mem2reg, op, link, halted, illegal, pc, icount};
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Cycle monitor: one expected observation per busy cycle.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = sample();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle@%0t: got ctl=%b op=%b lk/h/il=%b%b%b pc=%h ic=%0d expected ctl=%b op=%b lk/h/il=%b%b%b pc=%h ic=%0d",
                   $time, {a.regdst, a.regwrite, a.alusrc, a.memread, a.memwrite, a.mem2reg}, a.op,
                   a.link, a.halted, a.illegal, a.pc, a.icount,
                   {e.regdst, e.regwrite, e.alusrc, e.memread, e.memwrite, e.mem2reg}, e.op,
                   e.link, e.halted, e.illegal, e.pc, e.icount);
        end
      end
    end
  end

  function automatic cls_t classify(input logic [31:0] w);
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h20: return C_ADD;
        6'h22: return C_SUB;
        6'h24: return C_AND;
        6'h25: return C_OR;
        6'h2A: return C_SLT;
        default: return C_BAD;
      endcase
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04: return C_BEQ;
      6'h08: return C_ADDI;
      6'h02: return C_J;
`ifdef JAL_EN
      6'h03: return C_JAL;
`endif
      default: return C_BAD;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input cls_t c);
    case (c)
      C_OR:         return 3'b001;
      C_AND:        return 3'b000;
      C_SUB, C_BEQ: return 3'b110;
      C_SLT:        return 3'b111;
      default:      return 3'b010;
    endcase
  endfunction

  // Reference model: expands one instruction into its expected per-cycle observations.
  task automatic model_push(input logic [31:0] w, input logic z);
    cls_t        c = classify(w);
    obs_t        e = '0;
    logic [31:0] p4 = mpc + 32'd4;
    logic [31:0] tgt = {p4[31:28], w[25:0], 2'b00};
    logic [31:0] nxt = p4;
    logic        rtype = (c inside {C_ADD, C_SUB, C_AND, C_OR, C_SLT});
    e.pc = mpc; e.icount = mcnt;
    expq.push_back(e);
    e.pc = p4;
    expq.push_back(e);
    if (c == C_BAD) begin
      e.halted = 1'b1; e.illegal = 1'b1;
      repeat (HALT_CYCLES) expq.push_back(e);
      return;
    end
    case (c)
      C_J: nxt = tgt;
      C_JAL: begin
        e.regwrite = 1'b1; e.link = 1'b1; e.pc = tgt;
        expq.push_back(e);
        nxt = tgt;
      end
      C_BEQ: begin
        e.op = 3'b110;
        expq.push_back(e);
        if (z) nxt = p4 + {{14{w[15]}}, w[15:0], 2'b00};
      end
      default: begin
        e.op = alu_of(c);
        e.alusrc = (c inside {C_LW, C_SW, C_ADDI});
        e.regdst = rtype;
        expq.push_back(e);
        if (c == C_LW || c == C_SW) begin
          e.regdst = 1'b0; e.memread = (c == C_LW); e.memwrite = (c == C_SW);
          expq.push_back(e);
        end
        if (c != C_SW) begin
          e.regdst = rtype; e.regwrite = 1'b1; e.memwrite = 1'b0;
          e.memread = (c == C_LW); e.mem2reg = (c == C_LW);
          expq.push_back(e);
        end
      end
    endcase
    mpc = nxt;
    if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
  endtask

  // Drives one instruction for exactly the number of cycles the model expects it to occupy.
  task automatic issue(input logic [31:0] w, input logic z);
    int   n0 = expq.size();
    int   n;
    logic ill = (classify(w) == C_BAD);
    $display("issue ins=%h at pc=%h zero=%b", w, mpc, z);
    model_push(w, z);
    n = expq.size() - n0;
    ins = w;
    @(negedge clk);
    imm = {{16{w[15]}}, w[15:0]};
    zero = z;
    for (int i = 1; i < n; i++) begin
      if (ill) start = ~start;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0]  rs = 5'($urandom);
    logic [4:0]  rt = 5'($urandom);
    logic [4:0]  rd = 5'($urandom);
    logic [15:0] i16 = 16'($urandom);
    logic [25:0] t = 26'($urandom);
    int k;
`ifdef JAL_EN
    k = $urandom_range(0, 10);
`else
    k = $urandom_range(0, 9);
`endif
    case (k)
      0: return {6'h00, rs, rt, rd, 5'h0, 6'h20};
      1: return {6'h00, rs, rt, rd, 5'h0, 6'h22};
      2: return {6'h00, rs, rt, rd, 5'h0, 6'h24};
      3: return {6'h00, rs, rt, rd, 5'h0, 6'h25};
      4: return {6'h00, rs, rt, rd, 5'h0, 6'h2A};
      5: return {6'h23, rs, rt, i16};
      6: return {6'h2B, rs, rt, i16};
      7: return {6'h04, rs, rt, i16};
      8: return {6'h08, rs, rt, i16};
      9: return {6'h02, t};
      default: return {6'h03, t};
    endcase
  endfunction

  initial begin
    logic [31:0] off;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'd128);
    check("rst_icount", 32'(icount), 32'd0);
    check("rst_ctl", {23'b0, regdst, regwrite, alusrc, memread, memwrite, mem2reg, op}, 32'd0);
    check("rst_status", {29'b0, link, halted, illegal}, 32'd0);

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_pc", pc, 32'd128);
    check("idle_icount", 32'(icount), 32'd0);

    mpc = 32'd128; mcnt = 16'd0;
    start = 1'b1;
    issue(32'h00221820, 1'b0);
    issue(32'h8C430004, 1'b1);
    issue(32'h10000003, 1'b1);
    issue(32'h10000003, 1'b0);
    issue(32'h08000040, 1'b0);
`ifdef JAL_EN
    issue(32'h0C000040, 1'b0);
`endif
    // Branch to the last word of the address space so the next fetch wraps to 0.
    off = (32'hFFFFFFFC - (mpc + 32'd4)) >> 2;
    issue({6'h04, 10'h0, off[15:0]}, 1'b1);
    issue(32'h20420001, 1'b0);
    for (int i = 0; i < 50; i++) issue(rand_ins(), 1'($urandom));
    issue(32'hFC000000, 1'b0);
    start = 1'b0;

    rst_n = 1'b0;
    #1;
    check("halt_rst_pc", pc, 32'd128);
    check("halt_rst_status", {30'b0, halted, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ins = 32'hAC430008;
    imm = 32'd8;
    start = 1'b1;
    repeat (4) @(negedge clk);
    check("sw_mem_memwrite", 32'(memwrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("sw_rst_memwrite", 32'(memwrite), 32'd0);
    check("sw_rst_regwrite", 32'(regwrite), 32'd0);
    check("sw_rst_pc", pc, 32'd128);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_pc", pc, 32'd128);
    check("post_rst_icount", 32'(icount), 32'd0);

    mpc = 32'd128; mcnt = 16'd0;
    start = 1'b1;
    issue(32'h0C000040, 1'b0);
`ifdef JAL_EN
    issue(32'h00221821, 1'b0);
`endif
    start = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
